// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: receives the pixel plot stream, buffers accepted pixels in a
// small FIFO and writes them to the framebuffer port. A clear sequencer fills
// the whole screen with one colour on request, after the FIFO has drained.
//
// Ports:
//   clock, reset           single clock, async active-low reset
//   in_x/in_y/in_colour    pixel coordinate and colour (in_x is 8 bits so that
//                          columns 128..159 are addressable)
//   in_plot / in_ready     pixel valid / sink ready
//   clear_req/clear_colour single-cycle clear request and fill colour
//   clear_busy             clear pending or in progress
//   mem_addr/mem_data      framebuffer write address (y*SCREEN_W+x) and colour
//   mem_we / mem_ready     write request / framebuffer accepts this cycle
//   fifo_level             FIFO occupancy 0..FIFO_DEPTH
//   drop_clr/drop_count    only with PLOT_DROP_CNT_EN: saturating count of
//                          discarded out-of-range pixels, synchronous clear
module pixel_plot_sink #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned SCREEN_W   = 160,
    parameter int unsigned SCREEN_H   = 120,
    parameter int unsigned ADDR_W     = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    in_x,
    input  logic [6:0]                    in_y,
    input  logic [2:0]                    in_colour,
    input  logic                          in_plot,
    output logic                          in_ready,
    input  logic                          clear_req,
    input  logic [2:0]                    clear_colour,
    output logic                          clear_busy,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [2:0]                    mem_data,
    output logic                          mem_we,
`ifdef PLOT_DROP_CNT_EN
    input  logic                          drop_clr,
    output logic [7:0]                    drop_count,
`endif
    input  logic                          mem_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = ADDR_W + 3;
    localparam logic [7:0]        X_LIM    = 8'(SCREEN_W);
    localparam logic [6:0]        Y_LIM    = 7'(SCREEN_H);
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_CLEAR_WAIT = 2'd1,
        ST_CLEAR      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          clr_col_q, clr_col_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;

    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [PTR_W:0]      count;

    logic                fifo_empty, fifo_full;
    logic                in_range, push, pop;
    logic [ADDR_W-1:0]   push_addr;
    logic [ENTRY_W-1:0]  head;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign in_range   = (in_x < X_LIM) && (in_y < Y_LIM);
    assign push_addr  = ADDR_W'(in_y) * ADDR_W'(SCREEN_W) + ADDR_W'(in_x);
    assign head       = fifo_mem[rd_ptr];

    // Handshake completes for any pixel; only in-range ones enter the FIFO.
    assign push = in_plot && in_ready && in_range;
    assign pop  = !fifo_empty && mem_ready && (state_q != ST_CLEAR);

    // FIFO storage; contents are never observed while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {push_addr, in_colour};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            clr_col_q  <= '0;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_col_q  <= clr_col_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state and memory-port outputs.
    always_comb begin
        state_d    = state_q;
        clr_col_d  = clr_col_q;
        clr_addr_d = clr_addr_q;
        in_ready   = 1'b0;
        clear_busy = 1'b1;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;

        case (state_q)
            ST_RUN: begin
                clear_busy = 1'b0;
                in_ready   = !fifo_full;
                if (clear_req) begin
                    state_d   = ST_CLEAR_WAIT;
                    clr_col_d = clear_colour;
                end
            end
            ST_CLEAR_WAIT: begin
                if (fifo_empty) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                mem_we   = 1'b1;
                mem_addr = clr_addr_q;
                mem_data = clr_col_q;
                if (mem_ready) begin
                    if (clr_addr_q == CLR_LAST) begin
                        clr_addr_d = '0;
                        state_d    = ST_RUN;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_W'(1);
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Head of the FIFO drives the port in RUN and CLEAR_WAIT.
        if (state_q != ST_CLEAR && !fifo_empty) begin
            mem_we   = 1'b1;
            mem_addr = head[ENTRY_W-1:3];
            mem_data = head[2:0];
        end
    end

    assign fifo_level = count;

`ifdef PLOT_DROP_CNT_EN
    logic drop_hit;
    assign drop_hit = in_plot && in_ready && !in_range;

    // Saturating discard counter; clear wins over increment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            drop_count <= '0;
        end else if (drop_clr) begin
            drop_count <= '0;
        end else if (drop_hit && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
module tb_pixel_plot_sink;

    logic        clock;
    logic        reset;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_ready;
    logic        clear_req;
    logic [2:0]  clear_colour;
    logic        clear_busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic [3:0]  fifo_level;
`ifdef PLOT_DROP_CNT_EN
    logic        drop_clr;
    logic [7:0]  drop_count;
`endif

    int errors = 0;
    int checks = 0;

    pixel_plot_sink dut (
        .clock        (clock),
        .reset        (reset),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_colour    (in_colour),
        .in_plot      (in_plot),
        .in_ready     (in_ready),
        .clear_req    (clear_req),
        .clear_colour (clear_colour),
        .clear_busy   (clear_busy),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
`ifdef PLOT_DROP_CNT_EN
        .drop_clr     (drop_clr),
        .drop_count   (drop_count),
`endif
        .mem_ready    (mem_ready),
        .fifo_level   (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_x = '0; in_y = '0; in_colour = '0; in_plot = 1'b0;
        clear_req = 1'b0; clear_colour = '0; mem_ready = 1'b1;
`ifdef PLOT_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        repeat (2) @(posedge clock);
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        checks++; if (mem_addr !== 15'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d want 0", mem_addr); end
        checks++; if (mem_data !== 3'd0) begin errors++; $display("FAIL reset_mem_data: got %0d want 0", mem_data); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy: got %0b want 0", clear_busy); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_fifo_level: got %0d want 0", fifo_level); end
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_single_pixel;
        mem_ready = 1'b1;
        in_x = 8'd10; in_y = 7'd2; in_colour = 3'd7; in_plot = 1'b1;
        step;
        in_plot = 1'b0;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %0b want 1", mem_we); end
        checks++; if (mem_addr !== 15'd330) begin errors++; $display("FAIL single_addr: got %0d want 330", mem_addr); end
        checks++; if (mem_data !== 3'd7) begin errors++; $display("FAIL single_data: got %0d want 7", mem_data); end
        step;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_after: got %0b want 0", mem_we); end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level_after: got %0d want 0", fifo_level); end
    endtask

    task automatic test_back_to_back;
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_x = 8'(i); in_y = 7'd1; in_colour = 3'(i); in_plot = 1'b1;
            checks++;
            if (in_ready !== (i < 8)) begin
                errors++; $display("FAIL b2b_in_ready[%0d]: got %0b want %0b", i, in_ready, (i < 8));
            end
            step;
        end
        in_plot = 1'b0;
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL b2b_level_full: got %0d want 8", fifo_level); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0b want 0", in_ready); end
        step;
        checks++; if (mem_addr !== 15'd160) begin errors++; $display("FAIL b2b_stall_addr: got %0d want 160", mem_addr); end
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mem_we !== 1'b1 || mem_addr !== 15'(160 + i) || mem_data !== 3'(i)) begin
                errors++;
                $display("FAIL b2b_drain[%0d]: got we=%0b addr=%0d data=%0d want we=1 addr=%0d data=%0d",
                         i, mem_we, mem_addr, mem_data, 160 + i, i);
            end
            step;
            if (i == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_pop: got %0b want 1", in_ready); end
            end
        end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL b2b_drained_we: got %0b want 0", mem_we); end
    endtask

    task automatic test_range;
        mem_ready = 1'b1;
        in_x = 8'd160; in_y = 7'd0; in_colour = 3'd1; in_plot = 1'b1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL range_x_ready: got %0b want 1", in_ready); end
        step;
        in_x = 8'd0; in_y = 7'd120;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL range_x_dropped: got we=%0b want 0", mem_we); end
        step;
        in_plot = 1'b0;
        checks++; if (mem_we !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL range_y_dropped: got we=%0b level=%0d want 0/0", mem_we, fifo_level);
        end
`ifdef PLOT_DROP_CNT_EN
        checks++; if (drop_count !== 8'd2) begin errors++; $display("FAIL range_drop_count: got %0d want 2", drop_count); end
        drop_clr = 1'b1;
        step;
        drop_clr = 1'b0;
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL range_drop_clr: got %0d want 0", drop_count); end
`endif
        in_x = 8'd159; in_y = 7'd119; in_colour = 3'd5; in_plot = 1'b1;
        step;
        in_plot = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd19199 || mem_data !== 3'd5) begin
            errors++; $display("FAIL range_corner: got we=%0b addr=%0d data=%0d want 1/19199/5", mem_we, mem_addr, mem_data);
        end
        step;
    endtask

    task automatic test_clear;
        int wr;
        int bad;
        int ea;
        int ed;
        mem_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_x = 8'(i); in_y = 7'd0; in_colour = 3'(i); in_plot = 1'b1;
            step;
        end
        in_plot = 1'b0;
        clear_req = 1'b1; clear_colour = 3'd4;
        step;
        clear_req = 1'b0; clear_colour = 3'd0;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise: got %0b want 1", clear_busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: got %0b want 0", in_ready); end
        checks++; if (fifo_level !== 4'd3) begin errors++; $display("FAIL clear_level_kept: got %0d want 3", fifo_level); end
        mem_ready = 1'b1;
        wr = 0; bad = 0;
        for (int cyc = 0; cyc < 20000 && wr < 19203; cyc++) begin
            if (mem_we) begin
                if (wr < 3) begin ea = wr + 1; ed = wr + 1; end
                else begin ea = wr - 3; ed = 4; end
                if (mem_addr !== 15'(ea) || mem_data !== 3'(ed)) begin
                    if (bad < 4) $display("FAIL clear_write[%0d]: got addr=%0d data=%0d want addr=%0d data=%0d",
                                          wr, mem_addr, mem_data, ea, ed);
                    bad++;
                end
                wr++;
            end
            step;
        end
        checks++; if (wr != 19203) begin errors++; $display("FAIL clear_write_count: got %0d want 19203", wr); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence: got %0d bad writes want 0", bad); end
        checks++; if (clear_busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_done: got busy=%0b ready=%0b want 0/1", clear_busy, in_ready);
        end
    endtask

    task automatic test_clear_random_reset;
        int exp_addr;
        int bad;
        bit hit;
        bit rdy;
        mem_ready = 1'b0;
        clear_req = 1'b1; clear_colour = 3'd2;
        step;
        clear_colour = 3'd5;
        exp_addr = 0; bad = 0; hit = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            clear_req = (cyc == 10);
            if (mem_we) begin
                if (mem_addr !== 15'(exp_addr) || mem_data !== 3'd2) begin
                    if (bad < 4) $display("FAIL rclear_write: got addr=%0d data=%0d want addr=%0d data=2",
                                          mem_addr, mem_data, exp_addr);
                    bad++;
                end
                if (exp_addr == 5000) begin hit = 1'b1; break; end
                rdy = 1'($urandom_range(0, 1));
                mem_ready = rdy;
                if (rdy) exp_addr++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            step;
        end
        clear_req = 1'b0;
        checks++; if (!hit) begin errors++; $display("FAIL rclear_reach_5000: got addr=%0d want 5000", exp_addr); end
        checks++; if (bad != 0) begin errors++; $display("FAIL rclear_sequence: got %0d bad cycles want 0", bad); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 15'd0 || mem_data !== 3'd0) begin
            errors++; $display("FAIL rst_async_port: got we=%0b addr=%0d data=%0d want 0/0/0", mem_we, mem_addr, mem_data);
        end
        checks++; if (clear_busy !== 1'b0 || fifo_level !== 4'd0) begin
            errors++; $display("FAIL rst_async_state: got busy=%0b level=%0d want 0/0", clear_busy, fifo_level);
        end
        mem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || clear_busy !== 1'b0 || fifo_level !== 4'd0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_release: got ready=%0b busy=%0b level=%0d we=%0b want 1/0/0/0",
                               in_ready, clear_busy, fifo_level, mem_we);
        end
        in_x = 8'd5; in_y = 7'd0; in_colour = 3'd6; in_plot = 1'b1;
        step;
        in_plot = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 15'd5 || mem_data !== 3'd6) begin
            errors++; $display("FAIL rst_resume: got we=%0b addr=%0d data=%0d want 1/5/6", mem_we, mem_addr, mem_data);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_single_pixel;
        test_back_to_back;
        test_range;
        test_clear;
        test_clear_random_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
